// File: rtl/lbm_pkg.sv
// Shared definitions for the lattice-Boltzmann sequencer: FSM states and datapath mux codes.
package lbm_pkg;

    typedef enum logic [3:0] {
        IDLE, INIT, MOM_LD, MOM_WR, DIV_START, DIV_WAIT, U_LD, U_WR,
        EQ_LD, EQ_WR, COLL_LD, COLL_WR, STREAM, NEXT_CELL, NEXT_TIME, DONE
    } lbm_state_t;

    // Source selection for the f_in memory write port.
    localparam logic [1:0] FIN_INIT   = 2'd0;
    localparam logic [1:0] FIN_BOUNCE = 2'd1;
    localparam logic [1:0] FIN_STREAM = 2'd2;

    // Source selection for the ux register.
    localparam logic [1:0] UX_FLUID = 2'd0;
    localparam logic [1:0] UX_LID   = 2'd1;
    localparam logic [1:0] UX_WALL  = 2'd2;

endpackage

// File: rtl/lbm_wrap_counter.sv
// Up-counter with synchronous clear, terminal-count flag (count == MAX) and optional wrap to zero.
module lbm_wrap_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign tc = (count == MAX_V);

    // With wrap low the counter steps past MAX, so a saturating total stays readable.
    always_ff @(posedge Clk) begin
        if (!Reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (tc && wrap) count <= '0;
            else            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lbm_sequencer.sv
// Control sequencer for a lattice-Boltzmann cell pipeline: init, moments, divide, equilibrium,
// collision and streaming per cell, for MAX_TIME sweeps. Define LBM_SEQ_DIV_TIMEOUT_EN for a divider timeout.
module lbm_sequencer
    import lbm_pkg::*;
#(
    parameter int  GRID_X      = 16,
    parameter int  GRID_Y      = 16,
    parameter int  NQ          = 9,
    parameter int  MAX_TIME    = 10,
    parameter int  DIV_TIMEOUT = 64,
    localparam int ADDR_W      = $clog2(GRID_X * GRID_Y),
    localparam int DIR_W       = $clog2(NQ),
    localparam int T_W         = $clog2(MAX_TIME + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              pause,
    input  logic              div_valid,
    input  logic              lid,
    input  logic              wall,
    input  logic              stream_valid,
    output logic [ADDR_W-1:0] cell_addr,
    output logic [DIR_W-1:0]  dir,
    output logic [T_W-1:0]    time_step,
    output logic              we_p,
    output logic              we_u,
    output logic              we_feq,
    output logic              we_fout,
    output logic              we_fin,
    output logic              ld_moment,
    output logic              ld_u,
    output logic              ld_feq,
    output logic              ld_fout,
    output logic              sel_p_reg,
    output logic              sel_uy_reg,
    output logic [1:0]        sel_ux_reg,
    output logic [1:0]        sel_fin_src,
    output logic              div_start,
    output logic              busy,
    output logic              done,
    output logic              div_error,
    output logic [3:0]        state_dbg
);

    lbm_state_t state, state_next;
    logic       start_go, boundary;
    logic       cell_en, dir_en, time_en;
    logic       cell_last, dir_last, time_last;
    logic       div_timeout;

    assign start_go  = start && ((state == IDLE) || (state == DONE));
    assign boundary  = lid | wall;
    assign state_dbg = state;

    lbm_wrap_counter #(.WIDTH(ADDR_W), .MAX(GRID_X * GRID_Y - 1)) u_cell_cnt (
        .Clk(Clk), .Reset(Reset), .clear(start_go), .enable(cell_en), .wrap(1'b1),
        .count(cell_addr), .tc(cell_last)
    );

    lbm_wrap_counter #(.WIDTH(DIR_W), .MAX(NQ - 1)) u_dir_cnt (
        .Clk(Clk), .Reset(Reset), .clear(start_go), .enable(dir_en), .wrap(1'b1),
        .count(dir), .tc(dir_last)
    );

    // Terminal count fires on the last sweep so NEXT_TIME can decide before the increment lands.
    lbm_wrap_counter #(.WIDTH(T_W), .MAX(MAX_TIME - 1)) u_time_cnt (
        .Clk(Clk), .Reset(Reset), .clear(start_go), .enable(time_en), .wrap(1'b0),
        .count(time_step), .tc(time_last)
    );

`ifdef LBM_SEQ_DIV_TIMEOUT_EN
    localparam int TO_W = $clog2(DIV_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    logic            div_err_q;

    assign div_timeout = (to_cnt == TO_W'(DIV_TIMEOUT - 1));
    assign div_error   = div_err_q;

    always_ff @(posedge Clk) begin
        if (!Reset || state == DIV_START)                          to_cnt <= '0;
        else if (state == DIV_WAIT && !div_valid && !div_timeout)  to_cnt <= to_cnt + TO_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset || start_go)                                   div_err_q <= 1'b0;
        else if (state == DIV_WAIT && !div_valid && div_timeout)  div_err_q <= 1'b1;
    end
`else
    assign div_timeout = 1'b0;
    assign div_error   = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        cell_en     = 1'b0;
        dir_en      = 1'b0;
        time_en     = 1'b0;
        we_p        = 1'b0;
        we_u        = 1'b0;
        we_feq      = 1'b0;
        we_fout     = 1'b0;
        we_fin      = 1'b0;
        ld_moment   = 1'b0;
        ld_u        = 1'b0;
        ld_feq      = 1'b0;
        ld_fout     = 1'b0;
        sel_p_reg   = 1'b0;
        sel_uy_reg  = 1'b0;
        sel_ux_reg  = UX_FLUID;
        sel_fin_src = FIN_INIT;
        div_start   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = INIT;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = INIT;
            end
            INIT: begin
                we_p    = 1'b1;
                we_u    = 1'b1;
                we_fin  = 1'b1;
                cell_en = 1'b1;
                if (cell_last) state_next = MOM_LD;
            end
            MOM_LD: begin
                ld_moment  = 1'b1;
                sel_p_reg  = boundary;
                state_next = MOM_WR;
            end
            MOM_WR: begin
                we_p       = 1'b1;
                state_next = DIV_START;
            end
            DIV_START: begin
                div_start  = 1'b1;
                state_next = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_valid)        state_next = U_LD;
                else if (div_timeout) state_next = DONE;
            end
            U_LD: begin
                ld_u       = 1'b1;
                sel_uy_reg = boundary;
                if (lid)       sel_ux_reg = UX_LID;
                else if (wall) sel_ux_reg = UX_WALL;
                state_next = U_WR;
            end
            U_WR: begin
                we_u       = 1'b1;
                state_next = EQ_LD;
            end
            EQ_LD: begin
                ld_feq     = 1'b1;
                state_next = EQ_WR;
            end
            EQ_WR: begin
                we_feq = 1'b1;
                if (boundary) begin
                    we_fin      = 1'b1;
                    sel_fin_src = FIN_BOUNCE;
                end
                state_next = COLL_LD;
            end
            COLL_LD: begin
                ld_fout    = 1'b1;
                state_next = COLL_WR;
            end
            COLL_WR: begin
                we_fout    = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                we_fin      = stream_valid;
                sel_fin_src = FIN_STREAM;
                dir_en      = 1'b1;
                if (dir_last) state_next = NEXT_CELL;
            end
            NEXT_CELL: begin
                if (!pause) begin
                    cell_en    = 1'b1;
                    state_next = cell_last ? NEXT_TIME : MOM_LD;
                end
            end
            NEXT_TIME: begin
                time_en    = 1'b1;
                state_next = time_last ? DONE : MOM_LD;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lbm_sequencer.sv
// Cycle-exact scoreboard bench for lbm_sequencer on a 2x2 grid, NQ=9, two sweeps.
module tb_lbm_sequencer;
    import lbm_pkg::*;

    localparam int GRID_X      = 2;
    localparam int GRID_Y      = 2;
    localparam int NQ          = 9;
    localparam int MAX_TIME    = 2;
    localparam int DIV_TIMEOUT = 8;
    localparam int NCELL       = GRID_X * GRID_Y;
    localparam int ADDR_W      = $clog2(NCELL);
    localparam int DIR_W       = $clog2(NQ);
    localparam int T_W         = $clog2(MAX_TIME + 1);
    localparam int VW          = 4 + ADDR_W + DIR_W + T_W + 19;

    logic Clk, Reset, start, pause, div_valid, lid, wall, stream_valid;
    logic [ADDR_W-1:0] cell_addr;
    logic [DIR_W-1:0]  dir;
    logic [T_W-1:0]    time_step;
    logic we_p, we_u, we_feq, we_fout, we_fin;
    logic ld_moment, ld_u, ld_feq, ld_fout;
    logic sel_p_reg, sel_uy_reg;
    logic [1:0] sel_ux_reg, sel_fin_src;
    logic div_start, busy, done, div_error;
    logic [3:0] state_dbg;

    lbm_sequencer #(
        .GRID_X(GRID_X), .GRID_Y(GRID_Y), .NQ(NQ), .MAX_TIME(MAX_TIME), .DIV_TIMEOUT(DIV_TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pause(pause), .div_valid(div_valid),
        .lid(lid), .wall(wall), .stream_valid(stream_valid),
        .cell_addr(cell_addr), .dir(dir), .time_step(time_step),
        .we_p(we_p), .we_u(we_u), .we_feq(we_feq), .we_fout(we_fout), .we_fin(we_fin),
        .ld_moment(ld_moment), .ld_u(ld_u), .ld_feq(ld_feq), .ld_fout(ld_fout),
        .sel_p_reg(sel_p_reg), .sel_uy_reg(sel_uy_reg), .sel_ux_reg(sel_ux_reg),
        .sel_fin_src(sel_fin_src), .div_start(div_start), .busy(busy), .done(done),
        .div_error(div_error), .state_dbg(state_dbg)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard
    logic [VW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [VW-1:0] got_v;

    assign got_v = {state_dbg, cell_addr, dir, time_step, we_p, we_u, we_feq, we_fout, we_fin,
                    ld_moment, ld_u, ld_feq, ld_fout, sel_p_reg, sel_uy_reg, sel_ux_reg,
                    sel_fin_src, div_start, busy, done, div_error};

    task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() != 0) check_vec(tag_q.pop_front(), got_v, exp_q.pop_front());
    end

    // Expected outputs for one cycle, straight from the state output table.
    function automatic logic [VW-1:0] ev(input lbm_state_t s, input int c, input int d, input int t,
                                         input logic l, input logic w, input logic sv, input logic derr);
        logic wp, wu, wfeq, wfout, wfin, lm, lu, lfeq, lfout, sp, suy, ds, bsy, dn, de;
        logic [1:0] sux, sfin;
        wp = 0; wu = 0; wfeq = 0; wfout = 0; wfin = 0;
        lm = 0; lu = 0; lfeq = 0; lfout = 0; sp = 0; suy = 0; ds = 0;
        sux = 2'd0; sfin = 2'd0;
        bsy = (s != IDLE) && (s != DONE);
        dn  = (s == DONE);
        de  = (s == DONE) ? derr : 1'b0;
        case (s)
            INIT:      begin wp = 1; wu = 1; wfin = 1; end
            MOM_LD:    begin lm = 1; sp = l | w; end
            MOM_WR:    wp = 1;
            DIV_START: ds = 1;
            U_LD:      begin lu = 1; suy = l | w; sux = l ? 2'd1 : (w ? 2'd2 : 2'd0); end
            U_WR:      wu = 1;
            EQ_LD:     lfeq = 1;
            EQ_WR:     begin wfeq = 1; wfin = l | w; sfin = (l | w) ? 2'd1 : 2'd0; end
            COLL_LD:   lfout = 1;
            COLL_WR:   wfout = 1;
            STREAM:    begin wfin = sv; sfin = 2'd2; end
            default:   ;
        endcase
        return {4'(s), ADDR_W'(c), DIR_W'(d), T_W'(t), wp, wu, wfeq, wfout, wfin,
                lm, lu, lfeq, lfout, sp, suy, sux, sfin, ds, bsy, dn, de};
    endfunction

    // Scenario configuration
    logic          cell_lid  [NCELL];
    logic          cell_wall [NCELL];
    logic [NQ-1:0] sv_mask;
    int            pause_cell, pause_sweep, pause_len;
    bit            noisy;

    function automatic logic rnd_bit();
        return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Driver: apply one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input lbm_state_t s, input int c, input int d, input int t,
                       input logic l, input logic w, input logic sv, input logic dv,
                       input logic pz, input logic st, input logic rst_n, input logic derr);
        lid = l; wall = w; stream_valid = sv; div_valid = dv;
        pause = pz; start = st; Reset = rst_n;
        exp_q.push_back(ev(s, c, d, t, l, w, sv, derr));
        tag_q.push_back(s.name());
        @(posedge Clk);
        #1;
    endtask

    task automatic do_cell(input int c, input int t, input int rst_dir);
        logic l, w;
        int   extra;
        l = cell_lid[c];
        w = cell_wall[c];
        extra = noisy ? $urandom_range(0, 3) : 0;
        cyc(MOM_LD,    c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(MOM_WR,    c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(DIV_START, c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        for (int k = 0; k < extra; k++) cyc(DIV_WAIT, c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(DIV_WAIT,  c, 0, t, l, w, 1, 1, rnd_bit(), rnd_bit(), 1, 0);
        cyc(U_LD,      c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(U_WR,      c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(EQ_LD,     c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(EQ_WR,     c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(COLL_LD,   c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        cyc(COLL_WR,   c, 0, t, l, w, 1, 0, rnd_bit(), rnd_bit(), 1, 0);
        for (int d = 0; d < NQ; d++) begin
            cyc(STREAM, c, d, t, l, w, sv_mask[d], 0, rnd_bit(), rnd_bit(), (d == rst_dir) ? 1'b0 : 1'b1, 0);
            if (d == rst_dir) return;
        end
        if (t == pause_sweep && c == pause_cell)
            for (int k = 0; k < pause_len; k++) cyc(NEXT_CELL, c, 0, t, l, w, 1, 0, 1, rnd_bit(), 1, 0);
        cyc(NEXT_CELL, c, 0, t, l, w, 1, 0, 0, rnd_bit(), 1, 0);
    endtask

    task automatic start_run(input lbm_state_t from_s, input int from_t, input logic from_err);
        cyc(from_s, 0, 0, from_t, 0, 0, 0, 0, 0, 1, 1, from_err);
        for (int c = 0; c < NCELL; c++) cyc(INIT, c, 0, 0, 0, 0, 0, 0, rnd_bit(), rnd_bit(), 1, 0);
    endtask

    task automatic do_run(input lbm_state_t from_s, input int from_t, input logic from_err);
        start_run(from_s, from_t, from_err);
        for (int t = 0; t < MAX_TIME; t++) begin
            for (int c = 0; c < NCELL; c++) do_cell(c, t, -1);
            cyc(NEXT_TIME, 0, 0, t, 0, 0, 0, 0, rnd_bit(), rnd_bit(), 1, 0);
        end
        cyc(DONE, 0, 0, MAX_TIME, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(DONE, 0, 0, MAX_TIME, 0, 0, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic config_fixed();
        noisy = 0;
        cell_lid  = '{1, 1, 0, 0};
        cell_wall = '{0, 1, 1, 0};
        sv_mask = '1;
        sv_mask[3] = 1'b0;
        sv_mask[7] = 1'b0;
        pause_cell = 1; pause_sweep = 0; pause_len = 5;
    endtask

    initial begin
        Reset = 0; start = 0; pause = 0; div_valid = 0; lid = 0; wall = 0; stream_valid = 0;
        config_fixed();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        cyc(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // Boundary cells, masked directions, pause at cell 1
        do_run(IDLE, 0, 0);

        // Random boundaries, masks, divider latency, and stray start/pause while busy
        noisy = 1;
        for (int c = 0; c < NCELL; c++) begin
            cell_lid[c]  = 1'($urandom_range(0, 1));
            cell_wall[c] = 1'($urandom_range(0, 1));
        end
        sv_mask = NQ'($urandom);
        pause_cell = $urandom_range(0, NCELL - 1); pause_sweep = 1; pause_len = $urandom_range(1, 4);
        do_run(DONE, MAX_TIME, 0);
        config_fixed();

        // Divider result withheld
        start_run(DONE, MAX_TIME, 0);
        cyc(MOM_LD,    0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        cyc(MOM_WR,    0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        cyc(DIV_START, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
`ifdef LBM_SEQ_DIV_TIMEOUT_EN
        for (int k = 0; k < DIV_TIMEOUT; k++) cyc(DIV_WAIT, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        cyc(DONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        start_run(DONE, 0, 1);
`else
        for (int k = 0; k < 3 * DIV_TIMEOUT; k++) cyc(DIV_WAIT, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        cyc(DIV_WAIT, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        start_run(IDLE, 0, 0);
`endif

        // Reset in the middle of streaming, then a clean rerun
        do_cell(0, 0, 4);
        cyc(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        do_run(IDLE, 0, 0);

        check_vec("drain", VW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
